// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Purpose  : Per-functional-unit reservation station. Accepts renamed
//            instructions from the dispatcher, snoops the CDB for pending
//            operands, and issues the lowest-index operand-complete entry
//            to its functional unit over a valid/ready handshake.
// Options  : RS_WAKEUP_BYPASS_EN - when defined, a CDB broadcast can make an
//            entry selectable in the same cycle (0-cycle wakeup-to-issue).
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station #(
    parameter int RS_SIZE = 4,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int FUNC_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    // dispatcher load interface
    input  logic              load,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [TAG_W-1:0]  in_tag_dest,
    input  logic [TAG_W-1:0]  in_tag_src1,
    input  logic [TAG_W-1:0]  in_tag_src2,
    input  logic              in_ready_src1,
    input  logic              in_ready_src2,
    input  logic [XLEN-1:0]   in_value_src1,
    input  logic [XLEN-1:0]   in_value_src2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    output logic              is_full,
    // common data bus
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [XLEN-1:0]   cdb_value,
    // issue interface
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [FUNC_W-1:0] issue_func,
    output logic [TAG_W-1:0]  issue_tag_dest,
    output logic [XLEN-1:0]   issue_src1,
    output logic [XLEN-1:0]   issue_src2,
    output logic [XLEN-1:0]   issue_imm,
    output logic [XLEN-1:0]   issue_pc
);

    localparam int c_IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0] r_valid_q, w_valid_d;
    logic [RS_SIZE-1:0] r_rdy1_q,  w_rdy1_d;
    logic [RS_SIZE-1:0] r_rdy2_q,  w_rdy2_d;
    logic [FUNC_W-1:0]  r_func_q     [RS_SIZE];
    logic [FUNC_W-1:0]  w_func_d     [RS_SIZE];
    logic [TAG_W-1:0]   r_tag_dest_q [RS_SIZE];
    logic [TAG_W-1:0]   w_tag_dest_d [RS_SIZE];
    logic [TAG_W-1:0]   r_tag1_q     [RS_SIZE];
    logic [TAG_W-1:0]   w_tag1_d     [RS_SIZE];
    logic [TAG_W-1:0]   r_tag2_q     [RS_SIZE];
    logic [TAG_W-1:0]   w_tag2_d     [RS_SIZE];
    logic [XLEN-1:0]    r_val1_q     [RS_SIZE];
    logic [XLEN-1:0]    w_val1_d     [RS_SIZE];
    logic [XLEN-1:0]    r_val2_q     [RS_SIZE];
    logic [XLEN-1:0]    w_val2_d     [RS_SIZE];
    logic [XLEN-1:0]    r_imm_q      [RS_SIZE];
    logic [XLEN-1:0]    w_imm_d      [RS_SIZE];
    logic [XLEN-1:0]    r_pc_q       [RS_SIZE];
    logic [XLEN-1:0]    w_pc_d       [RS_SIZE];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0] w_match1;      // pending src1 matched by CDB
    logic [RS_SIZE-1:0] w_match2;      // pending src2 matched by CDB
    logic [RS_SIZE-1:0] w_selectable;  // entry eligible for issue
    logic [c_IDX_W-1:0] w_free_idx;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic               w_sel_found;
    logic               w_full;
    logic               w_load_accept;
    logic               w_fire;
    logic               w_cap1;
    logic               w_cap2;
    logic               w_issue_valid;

    // Fullness depends only on registered valid bits, never on this cycle's inputs
    assign w_full  = &r_valid_q;
    assign is_full = w_full;

    // A load accepted while not full always has a free slot to land in
    assign w_load_accept = load && !w_full && !flush;

    // Operand captured straight off the CDB when it broadcasts during the load
    assign w_cap1 = cdb_valid && !in_ready_src1 && (cdb_tag == in_tag_src1);
    assign w_cap2 = cdb_valid && !in_ready_src2 && (cdb_tag == in_tag_src2);

    // Per-entry CDB tag match and selection eligibility
    always_comb begin
        w_match1     = '0;
        w_match2     = '0;
        w_selectable = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_match1[i] = cdb_valid && !r_rdy1_q[i] && (r_tag1_q[i] == cdb_tag);
            w_match2[i] = cdb_valid && !r_rdy2_q[i] && (r_tag2_q[i] == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
            w_selectable[i] = r_valid_q[i]
                              && (r_rdy1_q[i] || w_match1[i])
                              && (r_rdy2_q[i] || w_match2[i]);
`else
            w_selectable[i] = r_valid_q[i] && r_rdy1_q[i] && r_rdy2_q[i];
`endif
        end
    end

    // Lowest-index free slot for loads (pre-edge valid bits only)
    always_comb begin
        w_free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_valid_q[i]) begin
                w_free_idx = i[c_IDX_W-1:0];
            end
        end
    end

    // Lowest-index ready entry wins the issue slot
    always_comb begin
        w_sel_idx   = '0;
        w_sel_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_selectable[i]) begin
                w_sel_idx   = i[c_IDX_W-1:0];
                w_sel_found = 1'b1;
            end
        end
    end

    assign w_issue_valid = w_sel_found && !flush;
    assign w_fire        = w_issue_valid && issue_ready;

    // Issue port: selected entry contents, forced to zero when nothing issues
    always_comb begin
        issue_valid    = w_issue_valid;
        issue_func     = '0;
        issue_tag_dest = '0;
        issue_src1     = '0;
        issue_src2     = '0;
        issue_imm      = '0;
        issue_pc       = '0;
        if (w_issue_valid) begin
            issue_func     = r_func_q[w_sel_idx];
            issue_tag_dest = r_tag_dest_q[w_sel_idx];
            issue_src1     = r_val1_q[w_sel_idx];
            issue_src2     = r_val2_q[w_sel_idx];
            issue_imm      = r_imm_q[w_sel_idx];
            issue_pc       = r_pc_q[w_sel_idx];
`ifdef RS_WAKEUP_BYPASS_EN
            // A selected operand that is not registered-ready must be the CDB match
            if (!r_rdy1_q[w_sel_idx]) begin
                issue_src1 = cdb_value;
            end
            if (!r_rdy2_q[w_sel_idx]) begin
                issue_src2 = cdb_value;
            end
`endif
        end
    end

    // Next-state: wakeup, then issue dequeue, then load; flush overrides all
    always_comb begin
        w_valid_d    = r_valid_q;
        w_rdy1_d     = r_rdy1_q;
        w_rdy2_d     = r_rdy2_q;
        w_func_d     = r_func_q;
        w_tag_dest_d = r_tag_dest_q;
        w_tag1_d     = r_tag1_q;
        w_tag2_d     = r_tag2_q;
        w_val1_d     = r_val1_q;
        w_val2_d     = r_val2_q;
        w_imm_d      = r_imm_q;
        w_pc_d       = r_pc_q;

        for (int i = 0; i < RS_SIZE; i++) begin
            if (r_valid_q[i] && w_match1[i]) begin
                w_rdy1_d[i] = 1'b1;
                w_val1_d[i] = cdb_value;
            end
            if (r_valid_q[i] && w_match2[i]) begin
                w_rdy2_d[i] = 1'b1;
                w_val2_d[i] = cdb_value;
            end
        end

        if (w_fire) begin
            w_valid_d[w_sel_idx] = 1'b0;
        end

        // Free slot is never the selected one: selection requires valid
        if (w_load_accept) begin
            w_valid_d[w_free_idx]    = 1'b1;
            w_func_d[w_free_idx]     = in_func;
            w_tag_dest_d[w_free_idx] = in_tag_dest;
            w_tag1_d[w_free_idx]     = in_tag_src1;
            w_tag2_d[w_free_idx]     = in_tag_src2;
            w_rdy1_d[w_free_idx]     = in_ready_src1 || w_cap1;
            w_rdy2_d[w_free_idx]     = in_ready_src2 || w_cap2;
            w_val1_d[w_free_idx]     = w_cap1 ? cdb_value : in_value_src1;
            w_val2_d[w_free_idx]     = w_cap2 ? cdb_value : in_value_src2;
            w_imm_d[w_free_idx]      = in_imm;
            w_pc_d[w_free_idx]       = in_pc;
        end

        if (flush) begin
            w_valid_d = '0;
        end
    end

    // Control state: valid and ready bits, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q <= '0;
            r_rdy1_q  <= '0;
            r_rdy2_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_rdy1_q  <= w_rdy1_d;
            r_rdy2_q  <= w_rdy2_d;
        end
    end

    // Payload state: meaningful only while the entry is valid, so no reset
    always_ff @(posedge clk) begin
        r_func_q     <= w_func_d;
        r_tag_dest_q <= w_tag_dest_d;
        r_tag1_q     <= w_tag1_d;
        r_tag2_q     <= w_tag2_d;
        r_val1_q     <= w_val1_d;
        r_val2_q     <= w_val2_d;
        r_imm_q      <= w_imm_d;
        r_pc_q       <= w_pc_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station
// Purpose  : Self-checking bench for reservation_station. Expected issue
//            packets are queued when instructions are loaded and compared by
//            an issue monitor on every fire; scenario tasks check timing and
//            fullness inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

`ifdef RS_WAKEUP_BYPASS_EN
    localparam logic c_BYP = 1'b1;
`else
    localparam logic c_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        load;
    logic [3:0]  in_func, in_tag_dest, in_tag_src1, in_tag_src2;
    logic        in_ready_src1, in_ready_src2;
    logic [31:0] in_value_src1, in_value_src2, in_imm, in_pc;
    logic        is_full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_func, issue_tag_dest;
    logic [31:0] issue_src1, issue_src2, issue_imm, issue_pc;

    typedef struct {
        logic [3:0]  func;
        logic [3:0]  tag;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    reservation_station #(.RS_SIZE(4), .XLEN(32), .TAG_W(4), .FUNC_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .load           (load),
        .in_func        (in_func),
        .in_tag_dest    (in_tag_dest),
        .in_tag_src1    (in_tag_src1),
        .in_tag_src2    (in_tag_src2),
        .in_ready_src1  (in_ready_src1),
        .in_ready_src2  (in_ready_src2),
        .in_value_src1  (in_value_src1),
        .in_value_src2  (in_value_src2),
        .in_imm         (in_imm),
        .in_pc          (in_pc),
        .is_full        (is_full),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_func     (issue_func),
        .issue_tag_dest (issue_tag_dest),
        .issue_src1     (issue_src1),
        .issue_src2     (issue_src2),
        .issue_imm      (issue_imm),
        .issue_pc       (issue_pc)
    );

    always #5 clk = ~clk;

    // Issue monitor: every fire must match the oldest queued expectation
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!reset && issue_valid && issue_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL issue_unexpected: got tag=%0d src1=%h src2=%h, required no issue",
                         issue_tag_dest, issue_src1, issue_src2);
            end else begin
                e = sb.pop_front();
                if (issue_func !== e.func || issue_tag_dest !== e.tag ||
                    issue_src1 !== e.s1 || issue_src2 !== e.s2 ||
                    issue_imm !== e.imm || issue_pc !== e.pc) begin
                    n_err++;
                    $display("FAIL issue_packet: got f=%0d t=%0d s1=%h s2=%h imm=%h pc=%h, required f=%0d t=%0d s1=%h s2=%h imm=%h pc=%h",
                             issue_func, issue_tag_dest, issue_src1, issue_src2, issue_imm, issue_pc,
                             e.func, e.tag, e.s1, e.s2, e.imm, e.pc);
                end
            end
        end
    end

    // Stimulus helpers
    task automatic drive_idle();
        load      = 1'b0;
        flush     = 1'b0;
        cdb_valid = 1'b0;
    endtask

    task automatic drive_load(input logic [3:0] f, input logic [3:0] td,
                              input logic [3:0] t1, input logic r1, input logic [31:0] v1,
                              input logic [3:0] t2, input logic r2, input logic [31:0] v2,
                              input logic [31:0] im, input logic [31:0] p);
        load          = 1'b1;
        in_func       = f;
        in_tag_dest   = td;
        in_tag_src1   = t1;
        in_ready_src1 = r1;
        in_value_src1 = v1;
        in_tag_src2   = t2;
        in_ready_src2 = r2;
        in_value_src2 = v2;
        in_imm        = im;
        in_pc         = p;
    endtask

    task automatic push_exp(input logic [3:0] f, input logic [3:0] td, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] im, input logic [31:0] p);
        exp_t e;
        e.func = f; e.tag = td; e.s1 = s1; e.s2 = s2; e.imm = im; e.pc = p;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_load(4'd1, 4'd1, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 32'h3, 32'h4);
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h0; issue_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        drive_idle();
        issue_ready = 1'b0;
        #1;
        n_vec++;
        if (is_full !== 1'b0) begin
            n_err++; $display("FAIL reset_is_full: got %b, required 0", is_full);
        end
        n_vec++;
        if (issue_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_issue_valid: got %b, required 0", issue_valid);
        end
        n_vec++;
        if ({issue_func, issue_tag_dest, issue_src1, issue_src2, issue_imm, issue_pc} !== '0) begin
            n_err++; $display("FAIL reset_issue_data: got tag=%0d s1=%h s2=%h, required all 0",
                              issue_tag_dest, issue_src1, issue_src2);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        drive_load(4'd2, 4'd3, 4'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 32'h10, 32'h400);
        issue_ready = 1'b1;
        push_exp(4'd2, 4'd3, 32'd5, 32'd7, 32'h10, 32'h400);
        #1;
        n_vec++;
        if (issue_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_not_yet: got issue_valid=%b, required 0", issue_valid);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_vec++;
        if (issue_valid !== 1'b1) begin
            n_err++; $display("FAIL basic_load_to_issue: got issue_valid=%b, required 1", issue_valid);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (issue_valid !== 1'b0 || sb.size() != 0) begin
            n_err++; $display("FAIL basic_empty_after: got issue_valid=%b pending=%0d, required 0 and 0",
                              issue_valid, sb.size());
        end
    endtask

    task automatic test_full_wakeup();
        logic prev_fire;
        logic drop_checked;
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_load(i[3:0], 4'(i + 1), 4'd2, 1'b0, 32'hDEAD, 4'd0, 1'b1, 32'h100 + i,
                       32'h200 + i, 32'h1000 + 4 * i);
            push_exp(i[3:0], 4'(i + 1), 32'hAA, 32'h100 + i, 32'h200 + i, 32'h1000 + 4 * i);
        end
        @(negedge clk);
        drive_load(4'd9, 4'd15, 4'd0, 1'b1, 32'h77, 4'd0, 1'b1, 32'h88, 32'h0, 32'h0);
        #1;
        n_vec++;
        if (is_full !== 1'b1) begin
            n_err++; $display("FAIL full_after_4: got is_full=%b, required 1", is_full);
        end
        @(negedge clk);
        drive_idle();
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'hAA;
        issue_ready = 1'b1;
        #1;
        n_vec++;
        if (is_full !== 1'b1 || issue_valid !== c_BYP) begin
            n_err++; $display("FAIL full_cdb_cycle: got is_full=%b issue_valid=%b, required 1 and %b",
                              is_full, issue_valid, c_BYP);
        end
        prev_fire    = issue_valid && issue_ready;
        drop_checked = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cdb_valid = 1'b0;
            #1;
            if (prev_fire && !drop_checked) begin
                drop_checked = 1'b1;
                n_vec++;
                if (is_full !== 1'b0) begin
                    n_err++; $display("FAIL full_drop_after_fire: got is_full=%b, required 0", is_full);
                end
            end
            prev_fire = issue_valid && issue_ready;
        end
        n_vec++;
        if (sb.size() != 0 || !drop_checked) begin
            n_err++; $display("FAIL full_drain: got pending=%0d fired=%b, required 0 and 1",
                              sb.size(), drop_checked);
            sb.delete();
        end
    endtask

    task automatic test_load_capture();
        @(negedge clk);
        drive_load(4'd5, 4'd8, 4'd0, 1'b1, 32'h11, 4'd6, 1'b0, 32'hBAD, 32'h22, 32'h33);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'h1234;
        issue_ready = 1'b1;
        push_exp(4'd5, 4'd8, 32'h11, 32'h1234, 32'h22, 32'h33);
        @(negedge clk);
        drive_idle();
        #1;
        n_vec++;
        if (issue_valid !== 1'b1) begin
            n_err++; $display("FAIL capture_ready: got issue_valid=%b, required 1", issue_valid);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL capture_drain: got pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_wakeup_latency();
        @(negedge clk);
        drive_load(4'd7, 4'd10, 4'd9, 1'b0, 32'h0, 4'd0, 1'b1, 32'h4242, 32'h5, 32'h6);
        issue_ready = 1'b1;
        push_exp(4'd7, 4'd10, 32'h99, 32'h4242, 32'h5, 32'h6);
        @(negedge clk);
        drive_idle();
        #1;
        n_vec++;
        if (issue_valid !== 1'b0) begin
            n_err++; $display("FAIL wake_waiting: got issue_valid=%b, required 0", issue_valid);
        end
        @(negedge clk);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'h99;
        #1;
        n_vec++;
        if (issue_valid !== c_BYP) begin
            n_err++; $display("FAIL wake_cycle_n: got issue_valid=%b, required %b", issue_valid, c_BYP);
        end
        @(negedge clk);
        cdb_valid = 1'b0;
        #1;
        n_vec++;
        if (issue_valid !== !c_BYP) begin
            n_err++; $display("FAIL wake_cycle_n1: got issue_valid=%b, required %b", issue_valid, !c_BYP);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL wake_drain: got pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_stall_order();
        issue_ready = 1'b0;
        @(negedge clk);
        drive_load(4'd1, 4'd1, 4'd0, 1'b1, 32'hA0, 4'd0, 1'b1, 32'hA1, 32'hA2, 32'hA3);
        push_exp(4'd1, 4'd1, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        @(negedge clk);
        drive_load(4'd2, 4'd2, 4'd12, 1'b0, 32'h0, 4'd0, 1'b1, 32'hB1, 32'hB2, 32'hB3);
        @(negedge clk);
        drive_load(4'd3, 4'd4, 4'd0, 1'b1, 32'hC0, 4'd0, 1'b1, 32'hC1, 32'hC2, 32'hC3);
        push_exp(4'd3, 4'd4, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            n_vec++;
            if (issue_valid !== 1'b1 || issue_tag_dest !== 4'd1 || issue_src1 !== 32'hA0 ||
                issue_src2 !== 32'hA1 || issue_pc !== 32'hA3) begin
                n_err++; $display("FAIL stall_hold: got v=%b tag=%0d s1=%h s2=%h pc=%h, required v=1 tag=1 s1=a0 s2=a1 pc=a3",
                                  issue_valid, issue_tag_dest, issue_src1, issue_src2, issue_pc);
            end
        end
        @(negedge clk);
        issue_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (issue_valid !== 1'b1 || issue_tag_dest !== 4'd4) begin
            n_err++; $display("FAIL stall_second: got v=%b tag=%0d, required v=1 tag=4", issue_valid, issue_tag_dest);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (issue_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_middle_waits: got issue_valid=%b, required 0", issue_valid);
        end
        push_exp(4'd2, 4'd2, 32'h5A5A, 32'hB1, 32'hB2, 32'hB3);
        @(negedge clk);
        cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'h5A5A;
        repeat (2) begin
            @(negedge clk);
            cdb_valid = 1'b0;
        end
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL stall_drain: got pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_load(4'd4, 4'(i + 11), 4'd0, 1'b1, 32'hF0 + i, 4'd0, 1'b1, 32'hF8, 32'h0, 32'h0);
        end
        @(negedge clk);
        drive_load(4'd4, 4'd14, 4'd3, 1'b0, 32'h0, 4'd0, 1'b1, 32'h1, 32'h0, 32'h0);
        flush = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'hEE;
        issue_ready = 1'b1;
        #1;
        n_vec++;
        if (issue_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_blocks_issue: got issue_valid=%b, required 0", issue_valid);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_vec++;
        if (is_full !== 1'b0 || issue_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_empty: got is_full=%b issue_valid=%b, required 0 and 0",
                              is_full, issue_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (issue_valid !== 1'b0) begin
                n_err++; $display("FAIL flush_stays_empty: got issue_valid=%b, required 0", issue_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        drive_load(4'd0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        load = 1'b0;
        cdb_tag = 4'd0; cdb_value = 32'h0; issue_ready = 1'b0;
        test_reset();
        test_basic();
        test_full_wakeup();
        test_load_capture();
        test_wakeup_latency();
        test_stall_order();
        test_flush();
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL final_scoreboard: got pending=%0d, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bounded runtime
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/reservation_station.md
# reservation_station

Reservation station on the receive side of the dispatcher's RS load interface, one instance per functional unit (LSU, MULT, BTU, ALU). It accepts renamed instructions when its load bit is high, reports fullness back so the dispatcher can stall, and captures CDB broadcasts for operands that are not yet ready. It issues one operand-complete instruction per cycle to its functional unit over a valid/ready handshake, and clears all entries on flush.

## Interface
- RS_SIZE, 4: entry count (≥2); index width IDX_W = $clog2(RS_SIZE)
- XLEN, 32: operand/PC/immediate width
- TAG_W, 4: ROB tag width
- FUNC_W, 4: FU function-code width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  mispredict squash; empties all entries
- load  in  1  dispatcher RS_load bit for this FU
- in_func  in  FUNC_W  function code
- in_tag_dest  in  TAG_W  ROB tag of result
- in_tag_src1 / in_tag_src2  in  TAG_W  producer tags
- in_ready_src1 / in_ready_src2  in  1  operand value already valid
- in_value_src1 / in_value_src2  in  XLEN  operand values (meaningful when ready)
- in_imm, in_pc  in  XLEN  passed through unchanged
- is_full  out  1  no free entry
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  TAG_W  broadcast ROB tag
- cdb_value  in  XLEN  broadcast result
- issue_valid  out  1  selected entry ready to execute
- issue_ready  in  1  FU accepts this cycle
- issue_func, issue_tag_dest, issue_src1, issue_src2, issue_imm, issue_pc  out  FUNC_W/TAG_W/XLEN×4  selected entry contents

## Operation
- Per entry: valid, func, tag_dest, tag1/tag2, rdy1/rdy2, val1/val2, imm, pc.
- Load: when load && !is_full && !flush, write the lowest-index entry whose registered valid is 0. A load while is_full is ignored: no state change.
- Load-time capture: if cdb_valid and cdb_tag equals in_tag_srcN while in_ready_srcN=0, store cdb_value with rdyN=1. Always on, independent of configuration.
- Wakeup: every valid entry with rdyN=0 and tagN==cdb_tag (cdb_valid) latches cdb_value and sets rdyN at the edge. Both sources may wake in the same cycle.
- Select: the lowest-index entry that is valid with rdy1&&rdy2 (see Configuration). issue_valid is 0 if none is selected or flush=1. Issue outputs show the selected entry and are 0 when issue_valid=0.
- Fire = issue_valid && issue_ready. The selected entry's valid clears at the edge. If not accepted, no hold is guaranteed: the selection may move to a lower index that becomes ready.
- A slot freed by fire is not reused by a load in the same cycle, because load uses the pre-edge valid bits.
- is_full = AND of the registered valid bits. It is combinational from state only, with no path from load, issue_ready or cdb.
- flush: all valid bits clear at the edge. Priority is flush > fire/load/wakeup.
- reset: all valid bits and rdy bits clear. Data fields are don't-care.

## Timing
- Reset values: is_full=0, issue_valid=0, all issue_* outputs 0.
- Load at edge N: entry is visible at N+1. If both operands are ready, issue_valid=1 in cycle N+1 (1-cycle load-to-issue).
- CDB in cycle N wakes an entry. It can issue in cycle N+1 by default, or in cycle N with the bypass enabled.
- Fire at edge N: is_full drops at N+1 if the RS was full.
- Reset or flush mid-operation: state is empty the next cycle. A CDB broadcast in the same cycle is discarded.

## Configuration
- RS_WAKEUP_BYPASS_EN defined: an entry counts as ready for selection if each source is either registered-ready or matched by the current cdb_valid/cdb_tag. The issue_srcN output muxes in cdb_value for the matched operand. This gives a 0-cycle wakeup-to-issue.
- Undefined: selection uses registered rdy bits only, so a woken entry issues one cycle after its CDB broadcast.

## Test plan
- Reset, then load tag_dest=3 with src1=5 and src2=7, both ready, issue_ready=1 → issue_valid at the next cycle with src1=5, src2=7, tag_dest=3, then empty.
- Load 4 entries with src1 waiting on tag 2 and issue_ready=0 → is_full=1. A 5th load is ignored. A CDB broadcast of tag 2 with value 0xAA wakes all 4, which issue in index order 0,1,2,3 over 4 cycles.
- Load with in_tag_src2=6 not ready while cdb_valid with tag 6 and value 0x1234 in the same cycle → entry is ready and issues with src2=0x1234.
- Entry waits on tag 9 and CDB broadcasts tag 9 in cycle N → issue_valid in cycle N with the bypass on, N+1 with it off.
- Entries 0 and 2 ready, issue_ready=0 for 3 cycles, then 1 → entry 0 issues first and entry 2 next. Contents stay unchanged while stalled.
- Flush with 3 valid entries in the same cycle as a load and a CDB broadcast → next cycle is_full=0, issue_valid=0, and nothing issues afterwards.
